// File: rtl/fdiv_mant_div_iter.sv
// Iterative radix-2 restoring mantissa divider: one quotient bit per clock,
// producing a 1.(QBITS-1) fixed-point quotient plus sticky for the round stage.
module fdiv_mant_div_iter #(
   parameter int unsigned QBITS = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [23:0]      a_mant,
   input  logic [23:0]      b_mant,
   output logic             busy,
   output logic             done,
   output logic [QBITS-1:0] q,
   output logic             sticky,
   output logic             dz
);

   localparam int unsigned CW = $clog2(QBITS + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [24:0]      rem_q, rem_d;
   logic [23:0]      breg_q, breg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [QBITS-1:0] q_q, q_d;
   logic             sticky_q, sticky_d;
   logic             dz_q, dz_d;

   logic             rem_ge;
   logic [24:0]      rem_sub;
   logic             last_iter;

   assign rem_ge    = rem_q >= {1'b0, breg_q};
   assign rem_sub   = rem_ge ? (rem_q - {1'b0, breg_q}) : rem_q;
   assign last_iter = (cnt_q == CW'(QBITS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = b_mant[23] ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            if (last_iter) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == S_RUN);
      done = (state_q == S_DONE);
   end

   always_comb begin
      rem_d    = rem_q;
      breg_d   = breg_q;
      cnt_d    = cnt_q;
      q_d      = q_q;
      sticky_d = sticky_q;
      dz_d     = dz_q;
      if (state_q == S_IDLE && start) begin
         rem_d    = {1'b0, a_mant};
         breg_d   = b_mant;
         cnt_d    = '0;
         q_d      = '0;
         sticky_d = 1'b0;
         dz_d     = 1'b0;
         if (!b_mant[23]) begin
            q_d  = '1;
            dz_d = 1'b1;
         end
      end else if (state_q == S_RUN) begin
         q_d   = {q_q[QBITS-2:0], rem_ge};
         // rem < 2*breg keeps bit 24 of rem_sub clear, so the shift loses nothing
         rem_d = rem_sub << 1;
         cnt_d = cnt_q + CW'(1);
         if (last_iter) begin
            sticky_d = |rem_sub;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q    <= '0;
         breg_q   <= '0;
         cnt_q    <= '0;
         q_q      <= '0;
         sticky_q <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         rem_q    <= rem_d;
         breg_q   <= breg_d;
         cnt_q    <= cnt_d;
         q_q      <= q_d;
         sticky_q <= sticky_d;
         dz_q     <= dz_d;
      end
   end

   assign q      = q_q;
   assign sticky = sticky_q;
   assign dz     = dz_q;

endmodule

// File: tb/tb_fdiv_mant_div_iter.sv
// Randomised self-checking bench for fdiv_mant_div_iter against an arithmetic
// floor/remainder reference model.
module tb_fdiv_mant_div_iter;

   localparam int unsigned QBITS = 26;

   logic             clk;
   logic             rst;
   logic             start;
   logic [23:0]      a_mant;
   logic [23:0]      b_mant;
   logic             busy;
   logic             done;
   logic [QBITS-1:0] q;
   logic             sticky;
   logic             dz;

   int unsigned total = 0;
   int unsigned bad   = 0;

   fdiv_mant_div_iter #(.QBITS(QBITS)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a_mant (a_mant),
      .b_mant (b_mant),
      .busy   (busy),
      .done   (done),
      .q      (q),
      .sticky (sticky),
      .dz     (dz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void ref_div(input logic [23:0] a, input logic [23:0] b,
                                   output logic [QBITS-1:0] rq, output logic rs,
                                   output logic rdz, output int lat);
      longint unsigned num;
      if (b[23] == 1'b0) begin
         rq  = '1;
         rs  = 1'b0;
         rdz = 1'b1;
         lat = 0;
      end else begin
         num = longint'(a) << (QBITS - 1);
         rq  = QBITS'(num / longint'(b));
         rs  = (num % longint'(b)) != 0;
         rdz = 1'b0;
         lat = QBITS;
      end
   endfunction

   // inj=1 pokes start with junk operands at RUN counts 3 and 20 and again while done=1
   task automatic run_div(input logic [23:0] a, input logic [23:0] b, input bit inj, input string tag);
      logic [QBITS-1:0] eq;
      logic             es, edz;
      int               elat, n, nbusy;
      ref_div(a, b, eq, es, edz, elat);
      @(negedge clk);
      start  = 1'b1;
      a_mant = a;
      b_mant = b;
      @(posedge clk);
      #1;
      start  = 1'b0;
      a_mant = 24'($urandom);
      b_mant = 24'($urandom);
      n = 0;
      nbusy = busy ? 1 : 0;
      while (!done && n < 60) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         n++;
         if (busy) nbusy++;
         if (inj && (n == 3 || n == 20)) begin
            start  = 1'b1;
            a_mant = 24'($urandom);
            b_mant = 24'($urandom) | 24'h800000;
         end
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_lat"}, n, elat);
      check({tag, "_q"}, q, eq);
      check({tag, "_sticky"}, sticky, es);
      check({tag, "_dz"}, dz, edz);
      if (!edz) check({tag, "_busycnt"}, nbusy, QBITS);
      if (inj) begin
         start  = 1'b1;
         a_mant = 24'h123456;
         b_mant = 24'h800001;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_pulse"}, done, 0);
      check({tag, "_idle"}, busy, 0);
      check({tag, "_hold"}, q, eq);
   endtask

   initial begin
      logic [23:0] ra, rb;
      rst    = 1'b1;
      start  = 1'b0;
      a_mant = '0;
      b_mant = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_q", q, 0);
      check("rst_sticky", sticky, 0);
      check("rst_dz", dz, 0);
      @(negedge clk);
      rst = 1'b0;

      run_div(24'h800000, 24'h800000, 0, "t1");
      run_div(24'hC00000, 24'h800000, 0, "t2");
      run_div(24'h800000, 24'hC00000, 0, "t3");
      run_div(24'hFFFFFF, 24'h800000, 0, "t4a");
      run_div(24'hFFFFFF, 24'h000001, 0, "t4b");
      run_div(24'h000000, 24'h9ABCDE, 0, "azero");
      run_div(24'h7FFFFF, 24'hFFFFFF, 0, "edge");
      run_div(24'hABCDEF, 24'h876543, 1, "t5");

      // reset aborts a divide at count 10
      @(negedge clk);
      start  = 1'b1;
      a_mant = 24'h555555;
      b_mant = 24'hAAAAAA;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("t6_busy", busy, 0);
      check("t6_done", done, 0);
      check("t6_q", q, 0);
      check("t6_sticky", sticky, 0);
      check("t6_dz", dz, 0);
      repeat (QBITS + 2) begin
         @(posedge clk);
         #1;
         if (done) check("t6_nodone", done, 0);
      end
      @(negedge clk);
      rst = 1'b0;
      run_div(24'h555555, 24'hAAAAAA, 0, "t6_after");

      for (int i = 0; i < 200; i++) begin
         ra = 24'($urandom);
         rb = 24'($urandom) | 24'h800000;
         run_div(ra, rb, (i % 25) == 0, "rnd");
      end
      for (int i = 0; i < 8; i++) begin
         ra = 24'($urandom);
         rb = 24'($urandom) & 24'h7FFFFF;
         run_div(ra, rb, 0, "rnd_dz");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
